upower_multicycle_control: RTL and testbench

- Multi-cycle control unit for the uPower load/store and R/I datapath.
- Accepts one 32-bit instruction at a time from the fetch side.
- Decodes it and drives the datapath control bundle (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, XO, ALU_OP) over a sequence of states.
- Handshakes with fetch on the input and with variable-latency data memory on the output side.

---
 rtl/upower_multicycle_control.sv | 214 +++++++++++++++++++++
 tb/tb_upower_multicycle_control.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upower_multicycle_control.sv
// Multi-cycle control unit for the uPower load/store and R/I datapath.
// Walks IDLE -> DECODE -> EXEC -> (MEM) -> WB, handshaking with fetch and
// with a variable-latency data memory.
module upower_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             mem_ready,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic [1:0]       RegDst,
    output logic             XO,
    output logic [3:0]       ALU_OP,
    output logic             done,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired_count
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_LWZ  = 6'd32;
    localparam logic [5:0] OP_STW  = 6'd36;
    localparam logic [5:0] OP_ADDI = 6'd14;
    localparam logic [5:0] OP_ORI  = 6'd24;
    localparam logic [5:0] OP_ANDI = 6'd28;
    localparam logic [5:0] OP_XO   = 6'd31;
    localparam logic [9:0] XO_ADD  = 10'd266;
    localparam logic [9:0] XO_SUBF = 10'd40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    // Decoded control fields held from EXEC until the instruction leaves.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       xo;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       is_load;
        logic       is_store;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            dec;
    logic             dec_ok;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             instr_ready_q, instr_ready_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             ir_unused;

    // Register, immediate and displacement fields are consumed by the datapath.
    assign ir_unused = ^{ir_q[25:11], ir_q[0]};

    // Instruction decode from the held instruction register.
    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        case (ir_q[31:26])
            OP_LWZ:  begin
                dec.alu_op = 4'b0010; dec.alu_src = 1'b1; dec.xo = 1'b1;
                dec.reg_dst = 2'b10; dec.mem_to_reg = 1'b1; dec.is_load = 1'b1;
            end
            OP_STW:  begin
                dec.alu_op = 4'b0010; dec.alu_src = 1'b1; dec.xo = 1'b1;
                dec.is_store = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_op = 4'b0010; dec.alu_src = 1'b1; dec.xo = 1'b1;
                dec.reg_dst = 2'b10;
            end
            OP_ORI:  begin
                dec.alu_op = 4'b0001; dec.alu_src = 1'b1;
            end
            OP_ANDI: begin
                dec.alu_op = 4'b0000; dec.alu_src = 1'b1;
            end
            OP_XO:   begin
                if (ir_q[10:1] == XO_ADD) begin
                    dec.alu_op = 4'b0010; dec.xo = 1'b1; dec.reg_dst = 2'b10;
                end else if (ir_q[10:1] == XO_SUBF) begin
                    dec.alu_op = 4'b0110; dec.xo = 1'b1; dec.reg_dst = 2'b10;
                end else begin
                    dec_ok = 1'b0;
                end
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Next-state, pulse outputs and next values of the registered controls.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ctrl_d    = ctrl_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        illegal   = 1'b0;
        bus_error = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    ctrl_d  = dec;
                    state_d = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                tmo_d   = '0;
                state_d = (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    tmo_d = '0;
                    if (ctrl_q.is_load) begin
                        state_d = S_WB;
                    end else begin
                        done    = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        ctrl_d  = '0;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    bus_error = 1'b1;
                    tmo_d     = '0;
                    ctrl_d    = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WB: begin
                done    = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                ctrl_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                ctrl_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        instr_ready_d = (state_d == S_IDLE);
        reg_write_d   = (state_d == S_WB);
        mem_read_d    = (state_d == S_MEM) && ctrl_d.is_load;
        mem_write_d   = (state_d == S_MEM) && ctrl_d.is_store;
    end

    // State and registered control outputs; reset drops any memory access at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            ir_q          <= '0;
            ctrl_q        <= '0;
            tmo_q         <= '0;
            cnt_q         <= '0;
            instr_ready_q <= 1'b1;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            ctrl_q        <= ctrl_d;
            tmo_q         <= tmo_d;
            cnt_q         <= cnt_d;
            instr_ready_q <= instr_ready_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

    assign instr_ready   = instr_ready_q;
    assign RegWrite      = reg_write_q;
    assign MemRead       = mem_read_q;
    assign MemWrite      = mem_write_q;
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign ALUSrc        = ctrl_q.alu_src;
    assign RegDst        = ctrl_q.reg_dst;
    assign XO            = ctrl_q.xo;
    assign ALU_OP        = ctrl_q.alu_op;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_upower_multicycle_control.sv
// Directed self-checking bench for upower_multicycle_control.
module tb_upower_multicycle_control;

    localparam int unsigned CNT_W       = 2;
    localparam int unsigned MEM_TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic [31:0]      instruction;
    logic             instr_valid;
    logic             instr_ready;
    logic             mem_ready;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             ALUSrc;
    logic [1:0]       RegDst;
    logic             XO;
    logic [3:0]       ALU_OP;
    logic             done;
    logic             illegal;
    logic             bus_error;
    logic [CNT_W-1:0] retired_count;

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    // ori, andi., add, subf with expected {ALU_OP, ALUSrc, XO, RegDst}
    logic [31:0] alu_ins [4] = '{32'h6000_0000, 32'h7000_0000, 32'h7C00_0214, 32'h7C00_0050};
    logic [7:0]  alu_exp [4] = '{8'b0001_1_0_00, 8'b0000_1_0_00, 8'b0010_0_1_10, 8'b0110_0_1_10};
    logic [31:0] bad_ins [2] = '{32'h7C00_07CE, 32'h0000_0000};
    logic [1:0]  b2b_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    upower_multicycle_control #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .mem_ready    (mem_ready),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .ALUSrc       (ALUSrc),
        .RegDst       (RegDst),
        .XO           (XO),
        .ALU_OP       (ALU_OP),
        .done         (done),
        .illegal      (illegal),
        .bus_error    (bus_error),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; instruction = '0;
        #12;
        obs = {instr_ready, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst,
               XO, ALU_OP, done, illegal, bus_error};
        checks++;
        if (obs !== 16'h8000) begin
            errors++; $display("FAIL reset_outputs: got %h want 8000", obs);
        end
        checks++;
        if (retired_count !== 2'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", retired_count);
        end
        rst = 1'b1;
        exp_cnt = '0;
        step();
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle_ready: got %b want 1", instr_ready);
        end
    endtask

    task automatic test_addi(input string tag);
        logic [11:0] obs;
        issue(32'h3A20_0014);
        checks++;
        if ({instr_ready, ALU_OP, ALUSrc, XO, RegDst, RegWrite, done} !== 11'd0) begin
            errors++; $display("FAIL %s_decode: ready=%b alu_op=%b alusrc=%b regwrite=%b",
                               tag, instr_ready, ALU_OP, ALUSrc, RegWrite);
        end
        step();
        obs = {ALU_OP, ALUSrc, XO, RegDst, RegWrite, done, MemRead, MemWrite};
        checks++;
        if (obs !== 12'b0010_1_1_10_0_0_0_0) begin
            errors++; $display("FAIL %s_exec: got %b want 001011100000", tag, obs);
        end
        step();
        obs = {RegWrite, ALUSrc, RegDst, XO, ALU_OP, done, MemRead, MemtoReg};
        checks++;
        if (obs !== 12'b1_1_10_1_0010_1_0_0) begin
            errors++; $display("FAIL %s_wb: got %b want 111010010100", tag, obs);
        end
        exp_cnt++;
        step();
        checks++;
        if ({instr_ready, RegWrite, done, ALU_OP, retired_count} !== {3'b100, 4'b0000, exp_cnt}) begin
            errors++; $display("FAIL %s_idle: ready=%b regwrite=%b done=%b alu_op=%b count=%0d want count %0d",
                               tag, instr_ready, RegWrite, done, ALU_OP, retired_count, exp_cnt);
        end
    endtask

    task automatic test_lwz_wait();
        logic [9:0] obs;
        mem_ready = 1'b0;
        issue(32'h8022_0001);
        step();
        obs = {MemRead, MemtoReg, ALU_OP, ALUSrc, XO, RegDst};
        checks++;
        if (obs !== 10'b0_1_0010_1_1_10) begin
            errors++; $display("FAIL lwz_exec: got %b want 0100101110", obs);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({MemRead, MemWrite, RegWrite, MemtoReg, done} !== 5'b10010) begin
                errors++; $display("FAIL lwz_mem%0d: memread=%b memwrite=%b regwrite=%b memtoreg=%b done=%b want 10010",
                                   i, MemRead, MemWrite, RegWrite, MemtoReg, done);
            end
            if (i == 3) mem_ready = 1'b1;
        end
        step();
        mem_ready = 1'b0;
        checks++;
        if ({RegWrite, MemRead, MemtoReg, done} !== 4'b1011) begin
            errors++; $display("FAIL lwz_wb: regwrite=%b memread=%b memtoreg=%b done=%b want 1011",
                               RegWrite, MemRead, MemtoReg, done);
        end
        exp_cnt++;
        step();
        checks++;
        if ({instr_ready, RegWrite, MemtoReg, retired_count} !== {3'b100, exp_cnt}) begin
            errors++; $display("FAIL lwz_idle: ready=%b regwrite=%b memtoreg=%b count=%0d want count %0d",
                               instr_ready, RegWrite, MemtoReg, retired_count, exp_cnt);
        end
    endtask

    task automatic test_stw_timeout();
        logic [4:0] exp;
        mem_ready = 1'b0;
        issue(32'h90A2_0002);
        step();
        checks++;
        if ({MemWrite, MemRead, ALU_OP, ALUSrc} !== 7'b0_0_0010_1) begin
            errors++; $display("FAIL stw_exec: memwrite=%b memread=%b alu_op=%b alusrc=%b",
                               MemWrite, MemRead, ALU_OP, ALUSrc);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            exp = {1'b1, 1'b0, 1'b0, (i == 15), 1'b0};
            checks++;
            if ({MemWrite, MemRead, RegWrite, bus_error, done} !== exp) begin
                errors++; $display("FAIL stw_mem%0d: got %b want %b", i,
                                   {MemWrite, MemRead, RegWrite, bus_error, done}, exp);
            end
        end
        step();
        checks++;
        if ({MemWrite, bus_error, instr_ready, RegWrite, done, retired_count} !== {5'b00100, exp_cnt}) begin
            errors++; $display("FAIL stw_after_timeout: memwrite=%b bus_error=%b ready=%b regwrite=%b count=%0d want count %0d",
                               MemWrite, bus_error, instr_ready, RegWrite, retired_count, exp_cnt);
        end
    endtask

    task automatic test_alu_decode();
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue(alu_ins[k]);
            step();
            checks++;
            if ({ALU_OP, ALUSrc, XO, RegDst} !== alu_exp[k]) begin
                errors++; $display("FAIL alu_fields%0d: got %b want %b", k,
                                   {ALU_OP, ALUSrc, XO, RegDst}, alu_exp[k]);
            end
            step();
            checks++;
            if ({RegWrite, MemRead, MemWrite, done} !== 4'b1001) begin
                errors++; $display("FAIL alu_wb%0d: got %b want 1001", k,
                                   {RegWrite, MemRead, MemWrite, done});
            end
            exp_cnt++;
            step();
            checks++;
            if ({instr_ready, retired_count} !== {1'b1, exp_cnt}) begin
                errors++; $display("FAIL alu_idle%0d: ready=%b count=%0d want 1 / %0d", k,
                                   instr_ready, retired_count, exp_cnt);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            issue(bad_ins[k]);
            checks++;
            if ({illegal, ALU_OP, ALUSrc, XO, RegDst, MemtoReg, RegWrite, MemRead, MemWrite, done, instr_ready}
                !== 16'b1_0000_0_0_00_0_0_0_0_0_0) begin
                errors++; $display("FAIL illegal_decode%0d: illegal=%b alu_op=%b alusrc=%b xo=%b regdst=%b regwrite=%b done=%b ready=%b",
                                   k, illegal, ALU_OP, ALUSrc, XO, RegDst, RegWrite, done, instr_ready);
            end
            step();
            checks++;
            if ({illegal, instr_ready, RegWrite, done, retired_count} !== {4'b0100, exp_cnt}) begin
                errors++; $display("FAIL illegal_idle%0d: illegal=%b ready=%b count=%0d want count %0d",
                                   k, illegal, instr_ready, retired_count, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        mem_ready = 1'b0;
        issue(32'h90A2_0002);
        step();
        step(); step(); step();
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++; $display("FAIL rst_mem_pre: memwrite=%b want 1", MemWrite);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({MemWrite, instr_ready, RegWrite, done, ALU_OP, retired_count} !== {4'b0100, 4'b0000, 2'd0}) begin
            errors++; $display("FAIL rst_mem_async: memwrite=%b ready=%b regwrite=%b alu_op=%b count=%0d want 0 1 0 0000 0",
                               MemWrite, instr_ready, RegWrite, ALU_OP, retired_count);
        end
        exp_cnt = '0;
        #2 rst = 1'b1;
        test_addi("post_rst_addi");
    endtask

    task automatic test_back_to_back();
        #2 rst = 1'b0;
        #3 rst = 1'b1;
        exp_cnt = '0;
        instruction = 32'h3A20_0014;
        instr_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if ({instr_ready, done} !== 2'b00) begin
                errors++; $display("FAIL b2b_accept%0d: ready=%b done=%b want 00", n, instr_ready, done);
            end
            step();
            step();
            checks++;
            if ({done, RegWrite} !== 2'b11) begin
                errors++; $display("FAIL b2b_wb%0d: done=%b regwrite=%b want 11", n, done, RegWrite);
            end
            step();
            checks++;
            if ({instr_ready, retired_count} !== {1'b1, b2b_seq[n]}) begin
                errors++; $display("FAIL b2b_count%0d: ready=%b count=%0d want 1 / %0d",
                                   n, instr_ready, retired_count, b2b_seq[n]);
            end
        end
        instr_valid = 1'b0;
        step();
        checks++;
        if ({instr_ready, retired_count} !== {1'b1, 2'd1}) begin
            errors++; $display("FAIL b2b_stop: ready=%b count=%0d want 1 / 1", instr_ready, retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_addi("addi");
        test_lwz_wait();
        test_stw_timeout();
        test_alu_decode();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
